ysyx_22050710_ifq: RTL and testbench
====================================

// Module: ysyx_22050710_ifq
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined NPC core. Replaces the
//  single-cycle fetch path. Streams sequential fetches to the inst SRAM and extracts the
//  32-bit instruction from each 64-bit read word. Buffers {pc, inst} pairs in a DEPTH-entry
//  queue and hands them to the decode stage over a valid/ready handshake.
//  Flushes all buffered and in-flight work on a redirect (branch, trap or mret).
// PARAMETERS
//  PC_W      64            pc width
//  ADDR_W    32            inst SRAM byte-address width
//  DATA_W    64            inst SRAM read-data width (fixed at 64 in this generation)
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  64'h8000_0000 first fetch address after reset
// PORTS
//  i_clk              in   1       clock
//  i_rst              in   1       synchronous, active-high reset
//  i_redirect         in   1       flush and restart fetch at i_redirect_pc
//  i_redirect_pc      in   PC_W    new fetch pc; bits [1:0] are forced to 0
//  o_valid            out  1       queue head valid toward decode
//  i_ready            in   1       decode accepts head
//  o_pc               out  PC_W    pc of head entry
//  o_inst             out  32      instruction of head entry
//  o_inst_sram_en     out  1       read request this cycle
//  o_inst_sram_addr   out  ADDR_W  byte address of the request (fetch_pc[ADDR_W-1:0])
//  i_inst_sram_rdata  in   DATA_W  read data, valid exactly 1 cycle after en
// BEHAVIOUR
//  - Reset values: o_valid=0, o_inst_sram_en=0, queue count=0, in-flight=0,
//    fetch_pc=RESET_PC. The first request is issued in the first cycle after i_rst falls.
//  - Issue: o_inst_sram_en=1 iff !i_rst && !i_redirect && (count + inflight) < DEPTH.
//    On issue, fetch_pc += 4, inflight_pc <= fetch_pc, and inflight <= 1; otherwise inflight <= 0.
//  - Response: the cycle after an issue, inst = inflight_pc[2] ? rdata[63:32] : rdata[31:0].
//    {inflight_pc, inst} is pushed into the queue. The credit rule guarantees a slot exists.
//  - Dequeue: a pop occurs when o_valid && i_ready. Push and pop may occur in the same
//    cycle; count is then unchanged. A push into an empty queue is visible on o_valid the next cycle.
//  - Throughput: for DEPTH >= 2 with i_ready held high, one instruction is delivered per
//    cycle after a 2-cycle fill (issue to response, then response to head).
//  - Backpressure: with i_ready=0, the queue fills to DEPTH and stops. o_inst_sram_en drops
//    once count + inflight == DEPTH. Head outputs hold stable while o_valid && !i_ready.
//  - Redirect (highest priority after reset):
//    - count <= 0, and the pending response (if any) is discarded.
//    - A pop in the same cycle is void, and fetch_pc <= {i_redirect_pc[PC_W-1:2], 2'b00}.
//    - No request is issued in the redirect cycle. The new stream starts the following
//      cycle, so the first new instruction reaches o_valid 3 cycles after the redirect.
//  - Back-to-back redirects: each one restarts fetch; only the last one takes effect.
//  - Reset mid-operation behaves as a redirect to RESET_PC and also clears inflight.
//    Responses arriving in the cycle after reset are discarded.
//  - Pointers: rd/wr pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//    count is $clog2(DEPTH)+1 bits. fetch_pc wraps modulo 2^PC_W.
// STRUCTURE
//  - Package ysyx_22050710_pkg: RESET_PC constant, INST_W=32, and typedef
//    fetch_entry_t {pc, inst}.
//  - Sub-module ysyx_22050710_sync_fifo holds the queue storage. It is parametrised
//    (WIDTH, DEPTH) with a flush input and count output.
//  - The parent holds fetch_pc, inflight/inflight_pc, credit logic and word select.
// TESTING
//  1. Reset then i_ready=1: addresses 0x8000_0000, _0004, _0008 issued on consecutive
//     cycles. o_pc sequence is 0x8000_0000, _0004, ... with 1 instr/cycle after fill.
//  2. Half select: rdata=64'hAAAA_AAAA_BBBB_BBBB. pc 0x...0 yields 0xBBBB_BBBB;
//     pc 0x...4 yields 0xAAAA_AAAA.
//  3. i_ready=0 from reset: exactly DEPTH=4 requests are issued, count reaches 4 and
//     en stays 0. Raising i_ready resumes issue one cycle later with no lost or duplicate pc.
//  4. Redirect to 0x8000_0103 while one request is in flight and the queue holds 2 entries:
//     - the queue empties and the stale response is dropped;
//     - the next request address is 0x8000_0100;
//     - o_valid rises 3 cycles later with o_pc=0x8000_0100.
//  5. Redirect in the same cycle as o_valid&&i_ready: the popped entry is not counted.
//     No entry from the old stream ever appears afterwards.
//  6. i_rst pulsed mid-stream with the queue full: all outputs return to reset values.
//     The fetch restarts at RESET_PC, and no pre-reset pc appears at o_pc.

Source files
------------

// File: rtl/ysyx_22050710_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050710_pkg
//  Purpose  : Shared constants and types for the instruction-fetch front end.
//             RESET_PC      - first fetch address after reset
//             INST_W        - instruction width carried through the queue
//             fetch_entry_t - one buffered {pc, inst} pair
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_22050710_pkg;

    localparam int          INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_ifq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050710_ifq_if
//  Purpose  : Bundles the fetch queue's redirect input, decode handshake and
//             inst SRAM port. Signal names are from the queue's point of view.
//  Ports    : master - the fetch queue (drives o_*, samples i_*)
//             slave  - the surroundings: decode stage, inst SRAM, redirect
//  Revision : 1.0  initial release
// ============================================================================
interface ysyx_22050710_ifq_if #(
    parameter int PC_W   = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();
    import ysyx_22050710_pkg::*;

    logic              i_redirect;
    logic [PC_W-1:0]   i_redirect_pc;
    logic              o_valid;
    logic              i_ready;
    logic [PC_W-1:0]   o_pc;
    logic [INST_W-1:0] o_inst;
    logic              o_inst_sram_en;
    logic [ADDR_W-1:0] o_inst_sram_addr;
    logic [DATA_W-1:0] i_inst_sram_rdata;

    modport master (
        input  i_redirect, i_redirect_pc, i_ready, i_inst_sram_rdata,
        output o_valid, o_pc, o_inst, o_inst_sram_en, o_inst_sram_addr
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_ready, i_inst_sram_rdata,
        input  o_valid, o_pc, o_inst, o_inst_sram_en, o_inst_sram_addr
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_22050710_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050710_sync_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO with a flush input.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             i_flush           empty the FIFO (overrides push and pop)
//             i_push, i_data    write one entry
//             i_pop             drop the head entry (ignored when empty)
//             o_data            head entry (meaningful while o_count != 0)
//             o_count           number of stored entries, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050710_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_full = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; a write during flush lands in a slot that is
    // no longer considered occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_ifq.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050710_ifq
//  Purpose  : Instruction-fetch front end. Streams sequential reads to the
//             inst SRAM, extracts the 32-bit instruction from each 64-bit
//             word, buffers {pc, inst} pairs and hands them to decode over a
//             valid/ready handshake. A redirect flushes all queued and
//             in-flight work and restarts fetch at the new pc.
//  Ports    : i_clk, i_rst      clock, synchronous active-high reset
//             bus (master)      redirect, decode handshake, inst SRAM port
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050710_ifq #(
    parameter int              PC_W     = 64,
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 64,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(ysyx_22050710_pkg::RESET_PC)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ysyx_22050710_ifq_if.master bus
);
    import ysyx_22050710_pkg::*;

    localparam int             CNT_W    = $clog2(DEPTH) + 1;
    localparam int             ENT_W    = PC_W + INST_W;
    localparam logic [CNT_W:0] c_credit = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_inflight_pc;
    logic              r_inflight;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_used;
    logic              w_flush;
    logic              w_issue;
    logic              w_valid;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;
    logic [INST_W-1:0] w_inst;
    logic [ENT_W-1:0]  w_push_data;
    logic [ENT_W-1:0]  w_head;
    logic              w_unused_pc_lsb;

    // Reset and redirect both discard everything queued or returning.
    assign w_flush = i_rst | bus.i_redirect;

    // Credit: a request may only leave when a queue slot is reserved for it,
    // counting the response still on its way back.
    assign w_used  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue = !w_flush && (w_used < c_credit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
        end else if (bus.i_redirect) begin
            r_fetch_pc <= {bus.i_redirect_pc[PC_W-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + PC_W'(4);
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // pc bit 2 picks the upper or lower word of the 64-bit read.
    assign w_rdata     = bus.i_inst_sram_rdata;
    assign w_inst      = r_inflight_pc[2] ? w_rdata[2*INST_W-1 -: INST_W]
                                          : w_rdata[INST_W-1:0];
    assign w_push_data = {r_inflight_pc, w_inst};

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && bus.i_ready;

    ysyx_22050710_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .i_flush (w_flush),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.o_valid          = w_valid;
    assign bus.o_pc             = w_head[ENT_W-1 -: PC_W];
    assign bus.o_inst           = w_head[INST_W-1:0];
    assign bus.o_inst_sram_en   = w_issue;
    assign bus.o_inst_sram_addr = r_fetch_pc[ADDR_W-1:0];

    // Redirect targets are word aligned; the low two bits are ignored.
    assign w_unused_pc_lsb = ^bus.i_redirect_pc[1:0];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_ifq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050710_ifq
//  Purpose  : Self-checking bench for the fetch queue. A queue-based model
//             predicts en/addr/valid/pc/inst every cycle; directed scenarios
//             add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050710_ifq;
    import ysyx_22050710_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050710_ifq_if #(.PC_W(64), .ADDR_W(32), .DATA_W(64)) bus ();

    ysyx_22050710_ifq #(
        .PC_W     (64),
        .ADDR_W   (32),
        .DATA_W   (64),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    fetch_entry_t mq[$];
    logic [63:0]  m_fpc = 64'h0;
    logic [63:0]  m_ipc = 64'h0;
    logic         m_inflight = 1'b0;
    logic         m_known = 1'b0;
    bit           mode = 1'b0;

    // SRAM model: request seen last cycle
    logic         p_en = 1'b0;
    logic [31:0]  p_addr = 32'h0;

    // samples of the current cycle
    logic         s_en, s_valid;
    logic [31:0]  s_addr, s_inst;
    logic [63:0]  s_pc;

    function automatic logic [63:0] sram_word(input logic [31:0] a, input bit md);
        logic [31:0] base;
        base = {a[31:3], 3'b000};
        if (md) return 64'hAAAA_AAAA_BBBB_BBBB;
        return {(base + 32'd4) ^ KEY, base ^ KEY};
    endfunction

    // The instruction at a pc, as the memory above defines it.
    function automatic logic [31:0] exp_inst(input logic [63:0] pc, input bit md);
        if (md) return pc[2] ? 32'hAAAA_AAAA : 32'hBBBB_BBBB;
        return pc[31:0] ^ KEY;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model at the rising edge.
    task automatic step(input logic rst_v, input logic redir_v,
                        input logic [63:0] rpc_v, input logic rdy_v);
        logic         e_en, e_valid;
        fetch_entry_t e;
        rst                   = rst_v;
        bus.i_redirect        = redir_v;
        bus.i_redirect_pc     = rpc_v;
        bus.i_ready           = rdy_v;
        bus.i_inst_sram_rdata = p_en ? sram_word(p_addr, mode) : {$urandom, $urandom};
        #1;
        s_en    = bus.o_inst_sram_en;
        s_addr  = bus.o_inst_sram_addr;
        s_valid = bus.o_valid;
        s_pc    = bus.o_pc;
        s_inst  = bus.o_inst;
        e_en    = !rst_v && !redir_v && ((mq.size() + int'(m_inflight)) < DEPTH);
        e_valid = (mq.size() != 0);
        if (m_known) begin
            chk("en", 64'(s_en), 64'(e_en));
            if (e_en) chk("addr", 64'(s_addr), 64'(m_fpc[31:0]));
            chk("valid", 64'(s_valid), 64'(e_valid));
            if (e_valid) begin
                chk("pc", s_pc, mq[0].pc);
                chk("inst", 64'(s_inst), 64'(mq[0].inst));
            end
        end
        p_en   = s_en;
        p_addr = s_addr;
        @(posedge clk);
        if (rst_v) begin
            mq.delete();
            m_inflight = 1'b0;
            m_fpc      = 64'h8000_0000;
            m_known    = 1'b1;
        end else if (redir_v) begin
            mq.delete();
            m_inflight = 1'b0;
            m_fpc      = {rpc_v[63:2], 2'b00};
        end else begin
            if (e_valid && rdy_v) void'(mq.pop_front());
            if (m_inflight) begin
                e.pc   = m_ipc;
                e.inst = exp_inst(m_ipc, mode);
                mq.push_back(e);
            end
            if (e_en) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 64'd4;
            end
            m_inflight = e_en;
        end
        @(negedge clk);
    endtask

    initial begin
        int n_iss;
        rst                   = 1'b1;
        bus.i_redirect        = 1'b0;
        bus.i_redirect_pc     = 64'h0;
        bus.i_ready           = 1'b0;
        bus.i_inst_sram_rdata = 64'h0;
        @(negedge clk);

        // reset state
        step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        chk("rst_valid", 64'(s_valid), 64'h0);
        chk("rst_en", 64'(s_en), 64'h0);

        // 1: sequential stream, ready high
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t1_en0", 64'(s_en), 64'h1);
        chk("t1_addr0", 64'(s_addr), 64'h8000_0000);
        chk("t1_valid0", 64'(s_valid), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t1_addr1", 64'(s_addr), 64'h8000_0004);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t1_addr2", 64'(s_addr), 64'h8000_0008);
        chk("t1_valid2", 64'(s_valid), 64'h1);
        chk("t1_pc2", s_pc, 64'h8000_0000);
        chk("t1_inst2", 64'(s_inst), 64'h40DE_0000);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t1_pc3", s_pc, 64'h8000_0004);
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 2: half-word select
        mode = 1'b1;
        step(1'b0, 1'b1, 64'h8000_1000, 1'b1);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t2_pc_lo", s_pc, 64'h8000_1000);
        chk("t2_inst_lo", 64'(s_inst), 64'hBBBB_BBBB);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t2_pc_hi", s_pc, 64'h8000_1004);
        chk("t2_inst_hi", 64'(s_inst), 64'hAAAA_AAAA);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1);
        mode = 1'b0;
        step(1'b0, 1'b1, 64'h8000_2000, 1'b1);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 3: backpressure from reset
        step(1'b1, 1'b0, 64'h0, 1'b0);
        n_iss = 0;
        repeat (8) begin
            step(1'b0, 1'b0, 64'h0, 1'b0);
            if (s_en) n_iss++;
        end
        chk("t3_issues", 64'(n_iss), 64'd4);
        chk("t3_en_full", 64'(s_en), 64'h0);
        chk("t3_head", s_pc, 64'h8000_0000);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t3_en_hold", 64'(s_en), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t3_en_resume", 64'(s_en), 64'h1);
        chk("t3_addr_resume", 64'(s_addr), 64'h8000_0010);
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 4: redirect with two queued and one in flight
        step(1'b1, 1'b0, 64'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h8000_0103, 1'b0);
        chk("t4_en_redir", 64'(s_en), 64'h0);
        chk("t4_valid_before", 64'(s_valid), 64'h1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t4_addr", 64'(s_addr), 64'h8000_0100);
        chk("t4_valid1", 64'(s_valid), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t4_valid2", 64'(s_valid), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t4_valid3", 64'(s_valid), 64'h1);
        chk("t4_pc3", s_pc, 64'h8000_0100);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 5: redirect coinciding with a pop
        step(1'b0, 1'b1, 64'h8000_0200, 1'b1);
        chk("t5_pop_same_cycle", 64'(s_valid), 64'h1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t5_valid2", 64'(s_valid), 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t5_pc3", s_pc, 64'h8000_0200);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 6: reset with the queue full
        step(1'b1, 1'b0, 64'h0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t6_full_valid", 64'(s_valid), 64'h1);
        chk("t6_full_en", 64'(s_en), 64'h0);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t6_valid_after", 64'(s_valid), 64'h0);
        chk("t6_addr_after", 64'(s_addr), 64'h8000_0000);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t6_pc_first", s_pc, 64'h8000_0000);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1);

        // 7: fetch_pc wraps at the top of the address space
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t7_addr0", 64'(s_addr), 64'hFFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t7_addr1", 64'(s_addr), 64'h0000_0000);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t7_pc0", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t7_pc1", s_pc, 64'h0);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
